// File: rtl/nav_pkg.sv
// -----------------------------------------------------------------------------
// nav_pkg
//
// Shared definitions for the navigation sensor samplers.
//
// Contents:
//   CH_W          width of one sensor channel value
//   PTR_W         width of the channel pointer (supports up to 8 channels)
//   CNT_W         width of the per-channel stability counter
//   scan_state_e  scan controller state encoding
//   sat_inc()     saturating increment for the stability counters
// -----------------------------------------------------------------------------
package nav_pkg;

  localparam int CH_W  = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // scanning disabled
    ST_WAIT   = 2'd1,  // waiting for the next prescaler tick
    ST_SAMPLE = 2'd2,  // capture the selected channel
    ST_EVAL   = 2'd3   // qualify the captured value and advance the pointer
  } scan_state_e;

  // Increment v but never beyond lim, so a counter held at its limit stays
  // there instead of wrapping back to a small value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage : nav_pkg

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
//
// Prescaler that produces a one-cycle TICK every DIV cycles while ENABLE is
// high. The count runs 0..DIV-1; TICK is asserted during the terminal count
// and the count then wraps to 0. Dropping ENABLE clears the count, so the
// first TICK after ENABLE rises always comes a full period later.
//
// Ports:
//   SCLK    in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   ENABLE  in   counting allowed
//   TICK    out  one-cycle pulse at terminal count
// -----------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic SCLK,
  input  logic RST_N,
  input  logic ENABLE,
  output logic TICK
);

  localparam int CNT_BITS = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_BITS-1:0] TERM = CNT_BITS'(DIV - 1);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  always_comb begin
    TICK  = ENABLE && (cnt_q == TERM);
    cnt_d = '0;
    if (ENABLE && !TICK) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : scan_tick_gen

// File: rtl/nav_sensor_scan_ctrl.sv
// -----------------------------------------------------------------------------
// nav_sensor_scan_ctrl
//
// Round-robin scan controller sharing one compare/qualify datapath across
// NUM_CH 8-bit sensor channels. On each prescaler tick one channel is
// sampled (SAMPLE) and qualified (EVAL). A channel's committed output only
// changes after STABLE_CNT consecutive identical samples of that channel, and
// only if the stable value differs from what is already committed.
//
// Timing: TICK at t -> SAMPLE at t+1 -> EVAL at t+2 -> CH_OUT/UPD at t+3.
// CH_IN is captured once per slot and must already be synchronized upstream.
//
// Ports:
//   SCLK    in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   ENABLE  in   scanning allowed (a started slot always completes)
//   CH_IN   in   raw channel values, channel k at [8k+7:8k]
//   CH_OUT  out  committed stable values, same packing
//   UPD     out  one-cycle pulse: a committed value changed
//   UPD_CH  out  index of the channel that changed, valid with UPD
//   BUSY    out  high in SAMPLE and EVAL
// -----------------------------------------------------------------------------
module nav_sensor_scan_ctrl
  import nav_pkg::*;
#(
  parameter int NUM_CH     = 4,     // 2..8
  parameter int SAMPLE_DIV = 1000,  // >= 4
  parameter int STABLE_CNT = 3      // 2..15
) (
  input  logic                     SCLK,
  input  logic                     RST_N,
  input  logic                     ENABLE,
  input  logic [NUM_CH*CH_W-1:0]   CH_IN,
  output logic [NUM_CH*CH_W-1:0]   CH_OUT,
  output logic                     UPD,
  output logic [PTR_W-1:0]         UPD_CH,
  output logic                     BUSY
);

  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CNT);
  localparam logic [PTR_W-1:0] LAST_CH    = PTR_W'(NUM_CH - 1);

  // ---------------------------------------------------------------------------
  // Scan tick
  // ---------------------------------------------------------------------------
  logic tick;

  scan_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .SCLK   (SCLK),
    .RST_N  (RST_N),
    .ENABLE (ENABLE),
    .TICK   (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  scan_state_e          state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]      sample_q, sample_d;
  logic                 upd_q, upd_d;
  logic [PTR_W-1:0]     upd_ch_q, upd_ch_d;

  logic [CH_W-1:0]      last_raw_q [NUM_CH];
  logic [CNT_W-1:0]     cnt_q      [NUM_CH];
  logic [CH_W-1:0]      ch_out_q   [NUM_CH];

  // ---------------------------------------------------------------------------
  // Shared datapath: select the channel under the pointer, then qualify.
  // Selection is a compare-per-channel mux so a pointer value >= NUM_CH can
  // never address a non-existent channel.
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]  raw_sel;
  logic [CH_W-1:0]  last_sel;
  logic [CNT_W-1:0] cnt_sel;
  logic [CH_W-1:0]  out_sel;
  logic [CNT_W-1:0] cnt_new;
  logic             commit;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    raw_sel  = '0;
    last_sel = '0;
    cnt_sel  = '0;
    out_sel  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ptr_q == PTR_W'(k)) begin
        raw_sel  = CH_IN[k*CH_W +: CH_W];
        last_sel = last_raw_q[k];
        cnt_sel  = cnt_q[k];
        out_sel  = ch_out_q[k];
      end
    end

    // A differing sample restarts the run at 1; a matching one extends it.
    if (sample_q == last_sel) begin
      cnt_new = sat_inc(cnt_sel, STABLE_LIM);
    end else begin
      cnt_new = CNT_W'(1);
    end

    // Commit only on a fully qualified value that is actually new.
    commit = (cnt_new == STABLE_LIM) && (sample_q != out_sel);
  end

  // ---------------------------------------------------------------------------
  // FSM next state and slot control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sample_d = sample_q;
    upd_d    = 1'b0;
    upd_ch_d = upd_ch_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          state_d = ST_SAMPLE;
        end
      end

      // ENABLE is ignored here and in EVAL: a started slot runs to the end.
      ST_SAMPLE: begin
        sample_d = raw_sel;
        state_d  = ST_EVAL;
      end

      ST_EVAL: begin
        upd_d = commit;
        if (commit) begin
          upd_ch_d = ptr_q;
        end
        ptr_d   = (ptr_q == LAST_CH) ? '0 : ptr_q + PTR_W'(1);
        state_d = ENABLE ? ST_WAIT : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      sample_q <= '0;
      upd_q    <= 1'b0;
      upd_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sample_q <= sample_d;
      upd_q    <= upd_d;
      upd_ch_q <= upd_ch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel registers: only the channel under the pointer is written,
  // and only in EVAL.
  // ---------------------------------------------------------------------------
  // NOTE: these arrays are small flop banks (not RAM) whose contents must be
  // known after reset, so they are reset like any other state register.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_CH; k++) begin
        last_raw_q[k] <= '0;
        cnt_q[k]      <= '0;
        ch_out_q[k]   <= '0;
      end
    end else if (state_q == ST_EVAL) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ptr_q == PTR_W'(k)) begin
          last_raw_q[k] <= sample_q;
          cnt_q[k]      <= cnt_new;
          if (commit) begin
            ch_out_q[k] <= sample_q;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign CH_OUT[g*CH_W +: CH_W] = ch_out_q[g];
  end

  assign UPD    = upd_q;
  assign UPD_CH = upd_ch_q;
  assign BUSY   = (state_q == ST_SAMPLE) || (state_q == ST_EVAL);

endmodule : nav_sensor_scan_ctrl

// File: tb/tb_nav_sensor_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nav_sensor_scan_ctrl
//
// Directed bench for nav_sensor_scan_ctrl with NUM_CH=4, SAMPLE_DIV=4,
// STABLE_CNT=3. Channel k is captured at slot k + 4*v after scanning starts,
// so with en = cycle count at the negedge where ENABLE rises, an update of
// channel k on visit v is visible at cycle en + 6 + 4k + 16v.
// -----------------------------------------------------------------------------
module tb_nav_sensor_scan_ctrl;

  localparam int NUM_CH     = 4;
  localparam int SAMPLE_DIV = 4;
  localparam int STABLE_CNT = 3;

  logic                SCLK;
  logic                RST_N;
  logic                ENABLE;
  logic [NUM_CH*8-1:0] CH_IN;
  logic [NUM_CH*8-1:0] CH_OUT;
  logic                UPD;
  logic [2:0]          UPD_CH;
  logic                BUSY;

  nav_sensor_scan_ctrl #(
    .NUM_CH     (NUM_CH),
    .SAMPLE_DIV (SAMPLE_DIV),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .SCLK   (SCLK),
    .RST_N  (RST_N),
    .ENABLE (ENABLE),
    .CH_IN  (CH_IN),
    .CH_OUT (CH_OUT),
    .UPD    (UPD),
    .UPD_CH (UPD_CH),
    .BUSY   (BUSY)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  int cyc = 0;
  always @(posedge SCLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // UPD event log, sampled on the falling edge.
  typedef struct {
    int ch;
    int val;
    int at;
  } upd_ev_t;

  upd_ev_t log_q[$];
  bit      busy_seen = 1'b0;

  always @(negedge SCLK) begin
    if (BUSY === 1'b1) busy_seen = 1'b1;
    if (UPD === 1'b1) begin
      upd_ev_t ev;
      ev.ch  = int'(UPD_CH);
      ev.val = int'(CH_OUT[int'(UPD_CH)*8 +: 8]);
      ev.at  = cyc;
      log_q.push_back(ev);
      check("upd_ch_range", {31'd0, (UPD_CH < 3'd4)}, 32'd1);
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge SCLK);
  endtask

  task automatic check_ev(input string tag, input int idx, input int ch,
                          input int val, input int at);
    if (idx >= log_q.size()) begin
      check({tag, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      check({tag, "_ch"},  32'(log_q[idx].ch),  32'(ch));
      check({tag, "_val"}, 32'(log_q[idx].val), 32'(val));
      check({tag, "_cyc"}, 32'(log_q[idx].at),  32'(at));
    end
  endtask

  task automatic do_reset();
    @(negedge SCLK);
    RST_N  = 1'b0;
    ENABLE = 1'b0;
    repeat (2) @(negedge SCLK);
    RST_N = 1'b1;
    log_q.delete();
  endtask

  task automatic start_scan(output int en);
    @(negedge SCLK);
    ENABLE = 1'b1;
    en = cyc;
  endtask

  int en;
  int r;

  initial begin
    RST_N  = 1'b0;
    ENABLE = 1'b0;
    CH_IN  = '1;

    // ---- Reset state with all inputs 0xFF --------------------------------
    repeat (3) @(negedge SCLK);
    check("rst_ch_out", CH_OUT, 32'h0);
    check("rst_upd",    {31'd0, UPD},  32'd0);
    check("rst_upd_ch", {29'd0, UPD_CH}, 32'd0);
    check("rst_busy",   {31'd0, BUSY}, 32'd0);
    RST_N = 1'b1;
    busy_seen = 1'b0;
    log_q.delete();
    wait_cyc(cyc + 5000);
    check("idle_no_busy", {31'd0, busy_seen}, 32'd0);
    check("idle_no_upd",  32'(log_q.size()), 32'd0);
    check("idle_ch_out",  CH_OUT, 32'h0);

    // ---- Basic commit: ch1 = 0x3C -----------------------------------------
    do_reset();
    CH_IN = 32'h0000_3C00;
    start_scan(en);
    wait_cyc(en + 3); check("basic_busy_wait",   {31'd0, BUSY}, 32'd0);
    wait_cyc(en + 4); check("basic_busy_sample", {31'd0, BUSY}, 32'd1);
    wait_cyc(en + 5); check("basic_busy_eval",   {31'd0, BUSY}, 32'd1);
    wait_cyc(en + 6); check("basic_busy_done",   {31'd0, BUSY}, 32'd0);
    wait_cyc(en + 41); check("basic_pre_commit", CH_OUT, 32'h0);
    wait_cyc(en + 110);
    check("basic_n_upd", 32'(log_q.size()), 32'd1);
    check_ev("basic", 0, 1, 8'h3C, en + 42);
    check("basic_ch_out", CH_OUT, 32'h0000_3C00);

    // ---- Glitch reject on ch2 ---------------------------------------------
    begin
      logic [7:0] seq [6];
      seq = '{8'h10, 8'h10, 8'h55, 8'h10, 8'h10, 8'h10};
      do_reset();
      CH_IN = '0;
      start_scan(en);
      for (int v = 0; v < 6; v++) begin
        wait_cyc(en + 5 + 16 * v);
        CH_IN[23:16] = seq[v];
      end
      wait_cyc(en + 126);
      check("glitch_n_upd", 32'(log_q.size()), 32'd1);
      check_ev("glitch", 0, 2, 8'h10, en + 94);
      check("glitch_ch_out", CH_OUT, 32'h0010_0000);
    end

    // ---- Round-robin wrap: all channels change ----------------------------
    do_reset();
    CH_IN = 32'h4433_2211;
    start_scan(en);
    wait_cyc(en + 51);
    CH_IN[7:0] = 8'hA5;
    wait_cyc(en + 120);
    check("rr_n_upd", 32'(log_q.size()), 32'd5);
    check_ev("rr0", 0, 0, 8'h11, en + 38);
    check_ev("rr1", 1, 1, 8'h22, en + 42);
    check_ev("rr2", 2, 2, 8'h33, en + 46);
    check_ev("rr3", 3, 3, 8'h44, en + 50);
    check_ev("rr4", 4, 0, 8'hA5, en + 86);
    check("rr_ch_out", CH_OUT, 32'h4433_22A5);

    // ---- ENABLE dropped in the SAMPLE cycle of ch1 ------------------------
    do_reset();
    CH_IN = 32'h7700_3C00;
    start_scan(en);
    wait_cyc(en + 8);
    check("drop_in_sample", {31'd0, BUSY}, 32'd1);
    ENABLE = 1'b0;
    wait_cyc(en + 9);  check("drop_eval_runs", {31'd0, BUSY}, 32'd1);
    wait_cyc(en + 10); check("drop_idle",      {31'd0, BUSY}, 32'd0);
    busy_seen = 1'b0;
    wait_cyc(en + 30);
    check("drop_no_busy", {31'd0, busy_seen}, 32'd0);
    ENABLE = 1'b1;
    r = cyc;
    wait_cyc(r + 3); check("reen_wait",   {31'd0, BUSY}, 32'd0);
    wait_cyc(r + 4); check("reen_sample", {31'd0, BUSY}, 32'd1);
    wait_cyc(r + 60);
    check("reen_n_upd", 32'(log_q.size()), 32'd2);
    check_ev("reen_ch1", 0, 1, 8'h3C, r + 34);
    check_ev("reen_ch3", 1, 3, 8'h77, r + 42);

    // ---- Async reset pulse during the committing EVAL of ch1 --------------
    do_reset();
    CH_IN = 32'h0000_3C00;
    start_scan(en);
    wait_cyc(en + 41);
    check("arst_in_eval", {31'd0, BUSY}, 32'd1);
    RST_N = 1'b0;
    #1;
    RST_N = 1'b1;
    wait_cyc(en + 42);
    check("arst_upd",    {31'd0, UPD}, 32'd0);
    check("arst_ch_out", CH_OUT, 32'h0);
    check("arst_busy",   {31'd0, BUSY}, 32'd0);
    check("arst_no_ev",  32'(log_q.size()), 32'd0);
    wait_cyc(en + 100);
    check("arst_n_upd", 32'(log_q.size()), 32'd1);
    check_ev("arst_recommit", 0, 1, 8'h3C, en + 83);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_nav_sensor_scan_ctrl
